// File: rtl/flit_bus_master.sv
// flit_bus_master: Avalon-MM initiator that moves flits between local valid/ready ports and the flit mailbox slave
module flit_bus_master #(
    parameter int RX_DEPTH = 4,
    parameter int POLL_GAP = 8,
    parameter int CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    output logic [2:0]       address,
    output logic             read,
    input  logic [31:0]      readdata,
    output logic             write,
    output logic [31:0]      writedata,
    input  logic             irq,
    input  logic [31:0]      tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [31:0]      rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [CNT_W-1:0] tx_count,
    output logic [CNT_W-1:0] rx_count,
    output logic             busy
);
    typedef enum logic [2:0] {IDLE, POLL, WRITE, READ, GAP} state_t;

    localparam int AW = $clog2(RX_DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(POLL_GAP + 1);

    state_t           state_q, state_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             prio_q, prio_d;
    logic [31:0]      hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [31:0]      mem_q [RX_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] tx_count_q, tx_count_d, rx_count_q, rx_count_d;
    logic             space, want_rd, want_wr, push, pop, capture, wr_done;

    // A pop in the deciding cycle is not credited, so READ is only chosen when room is certain
    assign space     = cnt_q < CW'(RX_DEPTH);
    assign want_rd   = readdata[1] && space;
    assign want_wr   = readdata[0] && hold_full_q;
    assign push      = state_q == READ;
    assign wr_done   = state_q == WRITE;
    assign pop       = rx_valid && rx_ready;
    assign capture   = tx_valid && !hold_full_q;
    assign tx_ready  = !hold_full_q;
    assign rx_valid  = cnt_q != CW'(0);
    assign rx_data   = mem_q[rd_ptr_q];
    assign busy      = state_q != IDLE;
    assign tx_count  = tx_count_q;
    assign rx_count  = rx_count_q;

    // Next state and single-cycle bus strobes; bus outputs follow the state register only
    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        prio_d    = prio_q;
        address   = 3'd0;
        read      = 1'b0;
        write     = 1'b0;
        writedata = 32'h0;
        case (state_q)
            IDLE:  state_d = (hold_full_q || (irq && space)) ? POLL : IDLE;
            POLL: begin
                read = 1'b1;
                if (want_rd && want_wr) state_d = prio_q ? WRITE : READ;
                else if (want_rd)       state_d = READ;
                else if (want_wr)       state_d = WRITE;
                else if (hold_full_q)   state_d = GAP;
                else                    state_d = IDLE;
                gap_d = '0;
            end
            WRITE: begin
                address   = 3'd1;
                write     = 1'b1;
                writedata = hold_q;
                state_d   = POLL;
                prio_d    = ~prio_q;
            end
            READ: begin
                address = 3'd2;
                read    = 1'b1;
                state_d = POLL;
                prio_d  = ~prio_q;
            end
            GAP: begin
                state_d = ((irq && space) || gap_q == GW'(POLL_GAP - 1)) ? POLL : GAP;
                gap_d   = gap_q + GW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Holding register, receive FIFO bookkeeping and wrapping statistics
    always_comb begin
        hold_d      = capture ? tx_data : hold_q;
        hold_full_d = capture | (hold_full_q & ~wr_done);
        wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d       = cnt_q + CW'(push) - CW'(pop);
        tx_count_d  = wr_done ? tx_count_q + CNT_W'(1) : tx_count_q;
        rx_count_d  = push ? rx_count_q + CNT_W'(1) : rx_count_q;
    end

    // State registers; reset aborts any access and discards held or queued flits
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            gap_q       <= '0;
            prio_q      <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            tx_count_q  <= '0;
            rx_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            prio_q      <= prio_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            tx_count_q  <= tx_count_d;
            rx_count_q  <= rx_count_d;
        end
    end

    // FIFO storage needs no reset because the pointers define which entries are live
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= readdata;
    end
endmodule

// File: tb/tb_flit_bus_master.sv
// tb_flit_bus_master: directed and random checks of flit_bus_master against a mailbox slave model and scoreboard
module tb_flit_bus_master;
    localparam int CNT_W    = 16;
    localparam int RX_DEPTH = 4;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic [2:0]       address;
    logic             read, write;
    logic [31:0]      readdata, writedata;
    logic             irq;
    logic [31:0]      tx_data = 32'h0;
    logic             tx_valid = 1'b0;
    logic             tx_ready;
    logic [31:0]      rx_data;
    logic             rx_valid;
    logic             rx_ready = 1'b0;
    logic [CNT_W-1:0] tx_count, rx_count;
    logic             busy;

    logic             sp = 1'b0;
    logic [29:0]      junk = '0;
    logic [31:0]      get_mem [256];
    int               get_idx = 0, get_end = 0;

    int               checks = 0, errors = 0;
    int               nw = 0, nr = 0, ncap = 0, rx_seen = 0;
    logic [31:0]      sent_q [$];
    logic [31:0]      exp_rx [$];
    string            trace = "";
    byte              op, prev_op = ".";
    logic [31:0]      prev_status = '0;
    bit               full_before;

    flit_bus_master #(.RX_DEPTH(RX_DEPTH), .POLL_GAP(8), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .address(address), .read(read), .readdata(readdata),
        .write(write), .writedata(writedata), .irq(irq), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .tx_count(tx_count), .rx_count(rx_count), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Mailbox slave: zero-latency reads; GA and irq mean undelivered get-flit data remains
    assign irq      = get_idx != get_end;
    assign readdata = !read ? 32'h0 :
                      address == 3'd0 ? {junk, irq, sp} :
                      address == 3'd2 ? get_mem[get_idx % 256] : 32'h0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chks(input string tag, input string obs, input string exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s: observed %s expected %s", tag, obs, exp);
        end
    endtask

    function automatic string rep(input byte c, input int n);
        string s = "";
        for (int i = 0; i < n; i++) s = $sformatf("%s%c", s, c);
        return s;
    endfunction

    task automatic tick();
        @(negedge CLK);
    endtask

    // Scoreboard: flits must leave in capture order, arrive in slave order, and every access follows a permitting poll
    always @(posedge CLK) begin
        if (RST) begin
            sent_q.delete();
            exp_rx.delete();
            nw = 0; nr = 0; ncap = 0; rx_seen = 0;
            prev_op = ".";
        end else begin
            op = write ? "W" : (read && address == 3'd2) ? "R" : read ? "P" : busy ? "g" : ".";
            full_before = exp_rx.size() >= RX_DEPTH;
            chk("rw_excl", read & write, 1'b0);
            chk("tx_ready", tx_ready, sent_q.size() == 0);
            chk("rx_valid", rx_valid, exp_rx.size() != 0);
            chk("tx_count", tx_count, CNT_W'(nw));
            chk("rx_count", rx_count, CNT_W'(nr));
            if (rx_valid && rx_ready && exp_rx.size() != 0) begin
                chk("rx_data", rx_data, exp_rx.pop_front());
                rx_seen++;
            end
            if (op == "W") begin
                chk("wr_after_poll", prev_op == "P" && prev_status[0], 1'b1);
                chk("wr_pending", sent_q.size() != 0, 1'b1);
                if (sent_q.size() != 0) chk("writedata", writedata, sent_q.pop_front());
                nw++;
            end
            if (op == "R") begin
                chk("rd_after_poll", prev_op == "P" && prev_status[1], 1'b1);
                chk("rd_not_full", full_before, 1'b0);
                exp_rx.push_back(readdata);
                get_idx <= get_idx + 1;
                nr++;
            end
            if (tx_valid && tx_ready) begin
                sent_q.push_back(tx_data);
                ncap++;
            end
            prev_op     = op;
            prev_status = readdata;
            trace       = $sformatf("%s%c", trace, op);
        end
    end

    task automatic add_get(input logic [31:0] v);
        get_mem[get_end % 256] = v;
        get_end++;
    endtask

    task automatic drain(input string tag);
        bit done = 1'b0;
        tx_valid = 1'b0;
        rx_ready = 1'b1;
        sp       = 1'b1;
        for (int k = 0; k < 1000 && !done; k++) begin
            tick();
            done = !busy && tx_ready && !rx_valid && get_idx == get_end;
        end
        chk(tag, done, 1'b1);
        chk({tag, "_tx"}, nw, ncap);
        chk({tag, "_rx"}, rx_seen, nr);
    endtask

    // Watchdog so a stuck design still ends the run
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick();
        chk("rst_read", read, 1'b0);
        chk("rst_write", write, 1'b0);
        chk("rst_addr", address, 3'd0);
        chk("rst_wdata", writedata, 32'h0);
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_tx_count", tx_count, 16'd0);
        chk("rst_rx_count", rx_count, 16'd0);
        chk("rst_busy", busy, 1'b0);
        tick();
        RST = 1'b0;
        trace = "";
        repeat (20) tick();
        chks("idle_trace", trace, rep(".", 20));
        chk("idle_busy", busy, 1'b0);

        // Single send with space available
        sp = 1'b1; tx_data = 32'hDEADBEEF; tx_valid = 1'b1; trace = "";
        tick();
        tx_valid = 1'b0;
        chk("t2_held", tx_ready, 1'b0);
        tick(); tick();
        chk("t2_write", write, 1'b1);
        chk("t2_addr", address, 3'd1);
        chk("t2_wdata", writedata, 32'hDEADBEEF);
        repeat (3) tick();
        chks("t2_trace", trace, "..PWP.");
        chk("t2_tx_count", tx_count, 16'd1);
        chk("t2_busy", busy, 1'b0);

        // No space: poll, eight gap cycles, poll again
        sp = 1'b0; tx_data = 32'h11223344; tx_valid = 1'b1; trace = "";
        tick();
        tx_valid = 1'b0;
        repeat (11) tick();
        chks("t3_gap_trace", trace, $sformatf("..P%sP", rep("g", 8)));
        chk("t3_held", tx_ready, 1'b0);
        repeat (4) tick();
        sp = 1'b1; trace = "";
        repeat (5) tick();
        chk("t3_write", write, 1'b1);
        chk("t3_held_in_write", tx_ready, 1'b0);
        tick();
        chk("t3_freed", tx_ready, 1'b1);
        repeat (2) tick();
        chks("t3_trace", trace, "ggggPWP.");
        chk("t3_tx_count", tx_count, 16'd2);

        // Receive five flits with a stalled sink: FIFO fills at four
        sp = 1'b0; rx_ready = 1'b0;
        for (int k = 1; k <= 5; k++) add_get(32'(k));
        trace = "";
        repeat (12) tick();
        chks("t4_fill_trace", trace, ".PRPRPRPRP..");
        chk("t4_full_valid", rx_valid, 1'b1);
        chk("t4_head", rx_data, 32'h1);
        chk("t4_rx_count4", rx_count, 16'd4);
        chk("t4_idle", busy, 1'b0);
        rx_ready = 1'b1; trace = "";
        repeat (8) tick();
        chks("t4_drain_trace", trace, "..PRP...");
        chk("t4_rx_count5", rx_count, 16'd5);
        chk("t4_empty", rx_valid, 1'b0);
        chk("t4_seen", rx_seen, 5);

        // Asynchronous reset in the middle of a WRITE
        sp = 1'b1; tx_data = 32'hCAFEF00D; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick(); tick();
        chk("t6_in_write", write, 1'b1);
        #2 RST = 1'b1;
        #1;
        chk("t6_write", write, 1'b0);
        chk("t6_read", read, 1'b0);
        chk("t6_addr", address, 3'd0);
        chk("t6_wdata", writedata, 32'h0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_tx_ready", tx_ready, 1'b1);
        chk("t6_rx_valid", rx_valid, 1'b0);
        chk("t6_tx_count", tx_count, 16'd0);
        chk("t6_rx_count", rx_count, 16'd0);
        tick(); tick();
        RST = 1'b0; trace = "";
        repeat (5) tick();
        chks("t6_trace", trace, rep(".", 5));
        chk("t6_tx_count_after", tx_count, 16'd0);

        // Contention: reads and writes alternate, read first after reset
        sp = 1'b1; rx_ready = 1'b1;
        for (int k = 0; k < 20; k++) add_get($urandom);
        tx_data = $urandom; tx_valid = 1'b1; trace = "";
        for (int k = 0; k < 13; k++) begin
            tick();
            tx_data = $urandom;
        end
        chks("t5_trace", trace, ".PRPWPRPWPRPW");
        drain("t5_drain");

        // Random traffic against the scoreboard
        for (int i = 0; i < 800; i++) begin
            tick();
            tx_valid = $urandom_range(0, 1) == 1;
            tx_data  = $urandom;
            rx_ready = $urandom_range(0, 3) != 0;
            sp       = $urandom_range(0, 2) != 0;
            junk     = 30'($urandom);
            if ($urandom_range(0, 3) == 0 && get_end - get_idx < 200) add_get($urandom);
        end
        drain("rand_drain");
        chk("rand_tx_count", tx_count, CNT_W'(nw));
        chk("rand_rx_count", rx_count, CNT_W'(nr));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
